serial_tx_piso: RTL and testbench

- Parallel-in serial-out transmitter: accepts a DATA_W-bit word on a load/ready handshake, then shifts it out on a single line as a framed serial stream.
- Frame order: start bit (0), data LSB first, optional parity, stop bit (1).
- Sits downstream of the team's load-enabled register storage and serialises a captured word onto a board-level wire.
- Output is fully registered; line idles high.

---
 rtl/serial_tx_piso.sv | 157 +++++++++++++++
 tb/tb_serial_tx_piso.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_tx_piso.sv
// serial_tx_piso: parallel-in serial-out framed transmitter.
// Frame on tx_out: start (0), DATA_W data bits LSB first, [parity], stop (1).
// Optional feature macro: SERIAL_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
//
// Handshake: a word on data_in is taken on a rising clk edge where
// load_in=1 and ready_out=1. ready_out is high only in IDLE and is derived
// from registered state, so it never depends combinationally on load_in.
// load_in while ready_out=0 is ignored and data_in is not sampled.
module serial_tx_piso #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset_al_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [2:0]        state_dbg
);

    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_nxt;
    logic [DATA_W-1:0] shift_q, shift_nxt;
    logic [BIT_W-1:0]  bit_q, bit_nxt;
    logic [CYC_W-1:0]  cyc_q, cyc_nxt;
    logic              tx_q, tx_nxt;
    logic              done_q, done_nxt;
    logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_nxt;
`endif

    // State and datapath registers; reset parks the line idle-high and drops any frame.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            shift_q <= shift_nxt;
            bit_q   <= bit_nxt;
            cyc_q   <= cyc_nxt;
            tx_q    <= tx_nxt;
            done_q  <= done_nxt;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_nxt;
`endif
        end
    end

    // Next-state logic; tx_nxt is the line value for the state being entered,
    // so tx_out changes on the same edge as the state register.
    always_comb begin
        state_nxt = state_q;
        shift_nxt = shift_q;
        bit_nxt   = bit_q;
        cyc_nxt   = cyc_q;
        tx_nxt    = tx_q;
        done_nxt  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_nxt   = par_q;
`endif
        bit_end   = (cyc_q == CYC_LAST);

        if (state_q != IDLE) begin
            cyc_nxt = bit_end ? '0 : cyc_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_nxt = 1'b1;
                if (load_in) begin
                    shift_nxt = data_in;
                    bit_nxt   = '0;
                    cyc_nxt   = '0;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
`ifdef SERIAL_TX_PARITY_EN
                    par_nxt   = ^data_in;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = par_q;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        shift_nxt = shift_q >> 1;
                        bit_nxt   = bit_q + 1'b1;
                        tx_nxt    = shift_nxt[0];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    assign tx_out    = tx_q;
    assign done_out  = done_q;
    assign ready_out = (state_q == IDLE);
    assign busy_out  = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_tx_piso.sv
// tb_serial_tx_piso: directed table-driven bench for serial_tx_piso
// (DATA_W=8, CLKS_PER_BIT=4). Follows SERIAL_TX_PARITY_EN like the RTL.
module tb_serial_tx_piso;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 3;
`else
    localparam int FRAME_BITS = DATA_W + 2;
`endif

    logic             clk;
    logic             reset_al_in;
    logic [DATA_W-1:0] data_in;
    logic             load_in;
    logic             ready_out;
    logic             tx_out;
    logic             busy_out;
    logic             done_out;
    logic [2:0]       state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    serial_tx_piso #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .data_in     (data_in),
        .load_in     (load_in),
        .ready_out   (ready_out),
        .tx_out      (tx_out),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .state_dbg   (state_dbg)
    );

    // Clock: rising edges at 5, 15, 25 ...; the bench drives and samples on falling edges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // frame: hand-written line bits for the no-parity frame, bit 0 sent first.
    // par: hand-computed even parity of data. inject_at: sample index at which a
    // one-cycle load of 0xFF is pulsed mid-frame (-1 = none).
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
        int         inject_at;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int k);
`ifdef SERIAL_TX_PARITY_EN
        if (k <= DATA_W) return v.frame[k];
        if (k == DATA_W + 1) return v.par;
        return 1'b1;
`else
        return v.frame[k];
`endif
    endfunction

    // Called on a falling edge with load_in=1 and data_in=v.data already set.
    // Checks every cycle of the frame and ends on the done_out cycle.
    task automatic frame_body(input vec_t v, input bit hold_load);
        int idx;
        @(negedge clk);
        for (int k = 0; k < FRAME_BITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                idx = k * CPB + c;
                if (!hold_load) begin
                    load_in = (idx == v.inject_at);
                    data_in = (idx == v.inject_at) ? 8'hFF : 8'h00;
                end
                check("tx_bit", {24'd0, v.data}, {24'd0, v.data}  ^ 32'(tx_out ^ exp_bit(v, k)));
                check("busy_rdy_done", {29'd0, busy_out, ready_out, done_out}, 32'b100);
                @(negedge clk);
            end
        end
        check("frame_end", {28'd0, tx_out, busy_out, ready_out, done_out}, 32'b1011);
        check("frame_end_state", {29'd0, state_dbg}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 10'b1101001010, 1'b0, -1};
        vecs[1] = '{8'h07, 10'b1000001110, 1'b1, -1};
        vecs[2] = '{8'h3C, 10'b1001111000, 1'b0, 14};
        vecs[3] = '{8'h55, 10'b1010101010, 1'b0, -1};
        vecs[4] = '{8'hF0, 10'b1111100000, 1'b0, -1};
        vecs[5] = '{8'hFF, 10'b1111111110, 1'b0, 22};
        vecs[6] = '{8'h00, 10'b1000000000, 1'b0, -1};
        vecs[7] = '{8'h81, 10'b1100000010, 1'b0, -1};
        vecs[8] = '{8'h42, 10'b1010000100, 1'b0, -1};

        reset_al_in = 1'b0;
        load_in     = 1'b0;
        data_in     = '0;

        // Reset held for 3 cycles, then 20 idle cycles with no load.
        repeat (3) begin
            @(negedge clk);
            check("reset_outs", {28'd0, tx_out, ready_out, busy_out, done_out}, 32'b1100);
        end
        reset_al_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outs", {28'd0, tx_out, ready_out, busy_out, done_out}, 32'b1100);
            check("idle_state", {29'd0, state_dbg}, 32'd0);
        end

        // Table: single frames, including loads pulsed while busy.
        for (int i = 0; i < 7; i++) begin
            data_in = vecs[i].data;
            load_in = 1'b1;
            frame_body(vecs[i], 1'b0);
            load_in = 1'b0;
            @(negedge clk);
            check("done_drops", {28'd0, tx_out, ready_out, busy_out, done_out}, 32'b1100);
        end

        // Back-to-back: load_in held high; second word taken on the done_out cycle.
        data_in = 8'h81;
        load_in = 1'b1;
        frame_body(vecs[7], 1'b1);
        data_in = 8'h42;
        frame_body(vecs[8], 1'b0);
        load_in = 1'b0;
        @(negedge clk);
        check("b2b_idle", {28'd0, tx_out, ready_out, busy_out, done_out}, 32'b1100);

        // Reset during data bit 3 of 0xF0, then a clean 0x55 frame.
        data_in = 8'hF0;
        load_in = 1'b1;
        @(negedge clk);
        load_in = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_reset_tx", {31'd0, tx_out}, 32'd0);
        check("pre_reset_state", {29'd0, state_dbg}, 32'd2);
        #2 reset_al_in = 1'b0;
        #1;
        check("async_reset_outs", {28'd0, tx_out, ready_out, busy_out, done_out}, 32'b1100);
        check("async_reset_state", {29'd0, state_dbg}, 32'd0);
        @(negedge clk);
        reset_al_in = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {28'd0, tx_out, ready_out, busy_out, done_out}, 32'b1100);
        data_in = 8'h55;
        load_in = 1'b1;
        frame_body(vecs[3], 1'b0);
        load_in = 1'b0;
        @(negedge clk);
        check("final_idle", {28'd0, tx_out, ready_out, busy_out, done_out}, 32'b1100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
